selector_juego: RTL and testbench
=================================

// Module: selector_juego
// PURPOSE
// - Produces the one-hot game-select vector consumed by the AY-3-8500 game-mode decoder.
// - Inputs: raw joystick NEXT/PREV buttons and clean direct-select keys from the keyboard decoder.
// - Debounces the buttons, steps through the games with wrap-around, and holds the selection.
// - Optionally pulses a game reset to the pong core when the selection changes.
// PARAMETERS
// - DEBOUNCE_CYCLES     500000  cycles a synced button must stay in its new level before it is accepted (>=2)
// - NUM_GAMES           7       number of selectable games, 1..7; bits >= NUM_GAMES are never selected
// - RESET_PULSE_CYCLES  16      o_game_reset pulse length in cycles (>=1); only used with GAMESEL_AUTORESET_EN
// PORTS
// - clk            in   1  core clock; everything in this block runs on it
// - reset          in   1  synchronous, active-high reset
// - i_btn_next_n   in   1  raw joystick button, active-low, asynchronous: select next game
// - i_btn_prev_n   in   1  raw joystick button, active-low, asynchronous: select previous game
// - i_direct       in   7  direct-select keys, active-high, clk-synchronous and clean; bit k = game k
// - o_gamesel      out  7  registered one-hot selection; bit0 tennis ... bit5 rifle2, bit6 extra
// - o_changed      out  1  one-cycle pulse in the first cycle that o_gamesel shows a new value
// - o_game_reset   out  1  game reset request to the pong core, active-high
// BEHAVIOUR
// - Reset values:
//   - o_gamesel = 7'b0000001 (tennis); o_changed = 0; o_game_reset = 0.
//   - All sync flops and debounced states = released; all counters = 0.
// - Button path (each button independently):
//   - Invert the raw input (pressed = 1), then pass it through a 2-flop synchronizer.
//   - Debounce counter: reset to 0 whenever the synced level equals the debounced level.
//   - While they differ, the counter increments.
//   - When the count reaches DEBOUNCE_CYCLES-1 and the levels still differ, the debounced level flips and the counter clears.
//   - Press event: one-cycle strobe on a released->pressed flip. Releasing a button produces no event.
// - Direct path:
//   - Rising edge per bit, from i_direct compared with its value in the previous cycle.
//   - If several bits rise in the same cycle, the lowest index wins.
//   - Rising bits at index >= NUM_GAMES are ignored.
// - Selection update, priority highest first:
//   1. Direct edge: load that one-hot bit.
//   2. NEXT strobe and PREV strobe in the same cycle: no change.
//   3. NEXT strobe: rotate toward the higher bit; bit NUM_GAMES-1 wraps to bit0.
//   4. PREV strobe: rotate toward the lower bit; bit0 wraps to bit NUM_GAMES-1.
// - Loading the already-selected game is not a change: o_changed stays 0 and no reset pulse is issued.
// - o_gamesel is always exactly one-hot; no X or Z is ever driven.
// - Latency, raw button held stable from cycle 0:
//   - o_gamesel updates at clock edge DEBOUNCE_CYCLES+3.
//   - o_changed is high for the cycle that follows that edge.
// - Latency, direct key rising in cycle 0: o_gamesel updates at edge 1.
// - A button held through reset release is seen as released at reset, so it produces one press after the debounce time.
// - Reset asserted mid-debounce or mid-pulse: everything returns to its reset value at the next edge; no event in flight survives.
// CONFIGURATION
// - With GAMESEL_AUTORESET_EN defined:
//   - Every change of o_gamesel loads a pulse counter with RESET_PULSE_CYCLES.
//   - o_game_reset is high while the counter is nonzero, starting the same cycle o_changed is high.
//   - A new change during a pulse restarts the count.
// - Without GAMESEL_AUTORESET_EN: o_game_reset is tied to 1'b0 and there is no counter logic.
// TESTING
// - Bench parameters: DEBOUNCE_CYCLES=4, NUM_GAMES=7, RESET_PULSE_CYCLES=3.
// - Reset, then idle: o_gamesel=7'b0000001, o_changed=0, o_game_reset=0 in every cycle.
// - Hold i_btn_next_n=0 for 20 cycles:
//   - o_gamesel becomes 7'b0000010 exactly at edge 7.
//   - o_changed is a single 1-cycle pulse and there is no second step.
// - Press PREV from tennis: o_gamesel becomes 7'b1000000 (wrap).
// - Rerun the same press with NUM_GAMES=6: o_gamesel becomes 7'b0100000.
// - Toggle i_btn_next_n every 2 cycles for 40 cycles (bounce), then release: o_gamesel unchanged.
// - Press NEXT and PREV together: o_gamesel unchanged, o_changed=0.
// - i_direct=7'b0010100 rising in one cycle:
//   - o_gamesel becomes 7'b0000100 one edge later.
//   - Keep the keys held: no further change.
// - Run with GAMESEL_AUTORESET_EN: a direct select of rifle1 (i_direct=7'b0010000) gives o_game_reset high for exactly 3 cycles.
// - Assert reset in the middle of that pulse: o_game_reset=0 and o_gamesel=7'b0000001 at the next edge.

Source files
------------

// File: rtl/selector_juego_if.sv
// Game-select bundle: raw joystick buttons and direct keys in, one-hot selection out.
interface selector_juego_if;
  logic       i_btn_next_n;
  logic       i_btn_prev_n;
  logic [6:0] i_direct;
  logic [6:0] o_gamesel;
  logic       o_changed;
  logic       o_game_reset;

  modport master (
    output i_btn_next_n, i_btn_prev_n, i_direct,
    input  o_gamesel, o_changed, o_game_reset
  );

  modport slave (
    input  i_btn_next_n, i_btn_prev_n, i_direct,
    output o_gamesel, o_changed, o_game_reset
  );
endinterface

// File: rtl/selector_juego.sv
// selector_juego: one-hot game selector for the AY-3-8500 game-mode decoder.
// Debounces NEXT/PREV joystick buttons, accepts direct-select keys, rotates
// with wrap-around over NUM_GAMES games and holds the selection.
// Optional feature macro GAMESEL_AUTORESET_EN: pulse o_game_reset for
// RESET_PULSE_CYCLES cycles on every selection change.
module selector_juego #(
  parameter int DEBOUNCE_CYCLES    = 500000,
  parameter int NUM_GAMES          = 7,
  parameter int RESET_PULSE_CYCLES = 16
) (
  input logic              clk,
  input logic              reset,
  selector_juego_if.slave  bus
);

  localparam int         CNT_W     = $clog2(DEBOUNCE_CYCLES);
  localparam logic [6:0] GAME_MASK = 7'((1 << NUM_GAMES) - 1);

  // Reject configurations the selector cannot represent at elaboration time.
  if (DEBOUNCE_CYCLES < 2 || NUM_GAMES < 1 || NUM_GAMES > 7 || RESET_PULSE_CYCLES < 1) begin : g_bad_params
    $error("selector_juego: illegal parameter combination");
  end

  // Index 0 = NEXT, index 1 = PREV; inverted so that pressed = 1.
  logic [1:0] btn_pressed;
  logic [1:0] press_evt;
  assign btn_pressed = {~bus.i_btn_prev_n, ~bus.i_btn_next_n};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_btn
      logic [1:0]       sync_q, sync_d;
      logic             deb_q, deb_d;
      logic [CNT_W-1:0] cnt_q, cnt_d;
      logic             press_q, press_d;

      // Synchronize, then accept a new level only after it has differed for DEBOUNCE_CYCLES cycles.
      always_comb begin
        sync_d  = {sync_q[0], btn_pressed[gi]};
        deb_d   = deb_q;
        cnt_d   = '0;
        press_d = 1'b0;
        if (sync_q[1] != deb_q) begin
          if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
            deb_d   = sync_q[1];
            press_d = sync_q[1];   // only a released->pressed flip is an event
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end

      // Button path registers; reset forces the released state.
      always_ff @(posedge clk) begin
        if (reset) begin
          sync_q  <= '0;
          deb_q   <= 1'b0;
          cnt_q   <= '0;
          press_q <= 1'b0;
        end else begin
          sync_q  <= sync_d;
          deb_q   <= deb_d;
          cnt_q   <= cnt_d;
          press_q <= press_d;
        end
      end

      assign press_evt[gi] = press_q;
    end
  endgenerate

  logic [6:0] direct_prev_q, direct_prev_d;
  logic [6:0] direct_rise, direct_pick;
  logic [6:0] rot_up, rot_dn;
  logic [6:0] gamesel_q, gamesel_d;
  logic       changed_q, changed_d;

  // Direct-key edges (lowest valid index wins) and the two rotations of the current selection.
  always_comb begin
    direct_prev_d = bus.i_direct;
    direct_rise   = bus.i_direct & ~direct_prev_q & GAME_MASK;
    direct_pick   = direct_rise & (~direct_rise + 7'd1);
    rot_up        = '0;
    rot_dn        = '0;
    rot_up[0]     = gamesel_q[NUM_GAMES-1];
    rot_dn[NUM_GAMES-1] = gamesel_q[0];
    for (int i = 1; i < NUM_GAMES; i++) begin
      rot_up[i]   = gamesel_q[i-1];
      rot_dn[i-1] = gamesel_q[i];
    end
  end

  // Selection priority: direct key, then simultaneous NEXT+PREV (hold), then NEXT, then PREV.
  always_comb begin
    gamesel_d = gamesel_q;
    if (|direct_rise) begin
      gamesel_d = direct_pick;
    end else if (!(press_evt[0] && press_evt[1])) begin
      if (press_evt[0]) begin
        gamesel_d = rot_up;
      end else if (press_evt[1]) begin
        gamesel_d = rot_dn;
      end
    end
    changed_d = (gamesel_d != gamesel_q);
  end

  // Selection registers; tennis after reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      direct_prev_q <= '0;
      gamesel_q     <= 7'b0000001;
      changed_q     <= 1'b0;
    end else begin
      direct_prev_q <= direct_prev_d;
      gamesel_q     <= gamesel_d;
      changed_q     <= changed_d;
    end
  end

  assign bus.o_gamesel = gamesel_q;
  assign bus.o_changed = changed_q;

`ifdef GAMESEL_AUTORESET_EN
  localparam int RP_W = $clog2(RESET_PULSE_CYCLES + 1);
  logic [RP_W-1:0] pulse_cnt_q, pulse_cnt_d;

  // Reload on every change so a change during a pulse restarts it; otherwise count down to zero.
  always_comb begin
    pulse_cnt_d = pulse_cnt_q;
    if (changed_d) begin
      pulse_cnt_d = RP_W'(RESET_PULSE_CYCLES);
    end else if (pulse_cnt_q != '0) begin
      pulse_cnt_d = pulse_cnt_q - RP_W'(1);
    end
  end

  // Pulse counter register.
  always_ff @(posedge clk) begin
    if (reset) begin
      pulse_cnt_q <= '0;
    end else begin
      pulse_cnt_q <= pulse_cnt_d;
    end
  end

  assign bus.o_game_reset = (pulse_cnt_q != '0);
`else
  assign bus.o_game_reset = 1'b0;
`endif

endmodule

// File: tb/tb_selector_juego.sv
// Bench for selector_juego: one DUT with NUM_GAMES=7 and one with NUM_GAMES=6,
// both driven by the same stimulus and checked every cycle against a
// per-game-index reference model.
module tb_selector_juego;

  localparam int D  = 4;
  localparam int RP = 3;
`ifdef GAMESEL_AUTORESET_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       next_n = 1'b1;
  logic       prev_n = 1'b1;
  logic [6:0] direct_v = '0;

  selector_juego_if bus7();
  selector_juego_if bus6();

  assign bus7.i_btn_next_n = next_n;
  assign bus7.i_btn_prev_n = prev_n;
  assign bus7.i_direct     = direct_v;
  assign bus6.i_btn_next_n = next_n;
  assign bus6.i_btn_prev_n = prev_n;
  assign bus6.i_direct     = direct_v;

  selector_juego #(.DEBOUNCE_CYCLES(D), .NUM_GAMES(7), .RESET_PULSE_CYCLES(RP)) dut7 (
    .clk(clk), .reset(rst), .bus(bus7));
  selector_juego #(.DEBOUNCE_CYCLES(D), .NUM_GAMES(6), .RESET_PULSE_CYCLES(RP)) dut6 (
    .clk(clk), .reset(rst), .bus(bus6));

  always #5 clk = ~clk;

  int checks = 0;
  int fails  = 0;

  // Reference model: selection as a game index, buttons as sample histories.
  int sel [2];
  int rp  [2];
  bit chg [2];
  int ng  [2] = '{7, 6};
  bit deb [2];
  bit pend[2];
  bit hist[2][$];
  logic [6:0] dprev;

  task automatic chk(input string tag, input logic [6:0] obs, input logic [6:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    logic [6:0] rise, mask;
    int nsel, sz;
    bit all_diff;
    if (rst) begin
      for (int m = 0; m < 2; m++) begin
        sel[m] = 0; rp[m] = 0; chg[m] = 1'b0;
      end
      for (int b = 0; b < 2; b++) begin
        deb[b] = 1'b0; pend[b] = 1'b0;
        hist[b].delete();
        hist[b].push_back(1'b0);   // both synchronizer stages read released
        hist[b].push_back(1'b0);
      end
      dprev = '0;
      return;
    end
    for (int m = 0; m < 2; m++) begin
      mask = 7'((1 << ng[m]) - 1);
      rise = direct_v & ~dprev & mask;
      nsel = sel[m];
      if (rise != 0) begin
        for (int k = 6; k >= 0; k--) if (rise[k]) nsel = k;
      end else if (!(pend[0] && pend[1])) begin
        if (pend[0]) nsel = (sel[m] + 1) % ng[m];
        else if (pend[1]) nsel = (sel[m] + ng[m] - 1) % ng[m];
      end
      chg[m] = (nsel != sel[m]);
      if (chg[m]) rp[m] = RP;
      else if (rp[m] > 0) rp[m]--;
      sel[m] = nsel;
    end
    dprev = direct_v;
    for (int b = 0; b < 2; b++) begin
      hist[b].push_back(b == 0 ? ~next_n : ~prev_n);
      pend[b] = 1'b0;
      sz = hist[b].size();
      // A level is accepted once the synced samples of the last D edges all differ from it.
      if (sz >= D + 2) begin
        all_diff = 1'b1;
        for (int j = 0; j < D; j++) if (hist[b][sz-3-j] == deb[b]) all_diff = 1'b0;
        if (all_diff) begin
          deb[b]  = ~deb[b];
          pend[b] = deb[b];
        end
      end
    end
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    chk("gamesel7", bus7.o_gamesel, 7'(1 << sel[0]));
    chk("changed7", {6'd0, bus7.o_changed}, {6'd0, chg[0]});
    chk("greset7",  {6'd0, bus7.o_game_reset}, {6'd0, AUTO && (rp[0] > 0)});
    chk("gamesel6", bus6.o_gamesel, 7'(1 << sel[1]));
    chk("changed6", {6'd0, bus6.o_changed}, {6'd0, chg[1]});
    chk("greset6",  {6'd0, bus6.o_game_reset}, {6'd0, AUTO && (rp[1] > 0)});
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  int cnt;

  initial begin
    // Reset and idle.
    do_reset();
    for (int i = 0; i < 5; i++) step();
    chk("idle_sel", bus7.o_gamesel, 7'b0000001);
    $display("phase reset/idle done");

    // Hold NEXT: selection steps once, at edge 7.
    next_n = 1'b0;
    cnt = 0;
    for (int i = 1; i <= 20; i++) begin
      step();
      if (i == 6) chk("next_edge6", bus7.o_gamesel, 7'b0000001);
      if (i == 7) chk("next_edge7", bus7.o_gamesel, 7'b0000010);
      if (bus7.o_changed) cnt++;
    end
    next_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      if (bus7.o_changed) cnt++;
    end
    chk("next_pulses", 7'(cnt), 7'd1);
    chk("next_final", bus7.o_gamesel, 7'b0000010);
    $display("phase next-hold done");

    // PREV from tennis wraps to the top game of each DUT.
    do_reset();
    prev_n = 1'b0;
    for (int i = 0; i < 12; i++) step();
    prev_n = 1'b1;
    for (int i = 0; i < 10; i++) step();
    chk("prev_wrap7", bus7.o_gamesel, 7'b1000000);
    chk("prev_wrap6", bus6.o_gamesel, 7'b0100000);
    $display("phase prev-wrap done");

    // Bounce shorter than the debounce time is rejected.
    for (int i = 0; i < 40; i++) begin
      if (i % 2 == 0) next_n = ~next_n;
      step();
    end
    next_n = 1'b1;
    for (int i = 0; i < 10; i++) step();
    chk("bounce7", bus7.o_gamesel, 7'b1000000);
    $display("phase bounce done");

    // NEXT and PREV together: no change.
    next_n = 1'b0; prev_n = 1'b0;
    cnt = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (bus7.o_changed || bus6.o_changed) cnt++;
    end
    next_n = 1'b1; prev_n = 1'b1;
    for (int i = 0; i < 10; i++) step();
    chk("both_changed", 7'(cnt), 7'd0);
    chk("both_sel7", bus7.o_gamesel, 7'b1000000);
    $display("phase next+prev done");

    // Direct select, several bits rising together: lowest wins, one edge later.
    do_reset();
    direct_v = 7'b0010100;
    step();
    chk("direct_low", bus7.o_gamesel, 7'b0000100);
    for (int i = 0; i < 5; i++) step();
    chk("direct_held", bus7.o_gamesel, 7'b0000100);
    direct_v = '0;
    step();
    $display("phase direct done");

    // Rifle1 select: reset pulse width, then reset during a pulse.
    direct_v = 7'b0010000;
    cnt = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (bus7.o_game_reset) cnt++;
    end
    chk("pulse_len", 7'(cnt), AUTO ? 7'd3 : 7'd0);
    direct_v = 7'b0000010;
    step();
    step();
    rst = 1'b1;
    step();
    chk("mid_rst_greset", {6'd0, bus7.o_game_reset}, 7'd0);
    chk("mid_rst_sel", bus7.o_gamesel, 7'b0000001);
    rst = 1'b0;
    direct_v = '0;
    step();
    $display("phase autoreset done");

    // Randomized mix of button holds, direct keys and occasional resets.
    for (int seg = 0; seg < 80; seg++) begin
      next_n   = $urandom_range(0, 2) != 0;
      prev_n   = $urandom_range(0, 2) != 0;
      direct_v = ($urandom_range(0, 3) == 0) ? 7'($urandom_range(0, 127)) : 7'd0;
      rst      = ($urandom_range(0, 30) == 0);
      cnt      = $urandom_range(1, 12);
      for (int i = 0; i < cnt; i++) begin
        step();
        rst = 1'b0;
      end
    end
    next_n = 1'b1; prev_n = 1'b1; direct_v = '0;
    for (int i = 0; i < 10; i++) step();
    $display("phase random done");

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
